// File: rtl/pre_processing_pipe.sv
// Pre-processing stage between camera capture and the Hough stages.
// Captures one N x N image over a 4-phase Req/Ack handshake. Rotates it by a
// run-time selected multiple of 90 degrees, writing one output row per clock.
// Also produces an optionally binarised copy for the Hough transform.
module pre_processing_pipe #(
  parameter int IMAGE_BITS = 8,
  parameter int MATRIX_N   = 8,
  parameter int FLAT_WIDE  = IMAGE_BITS * MATRIX_N * MATRIX_N
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [FLAT_WIDE-1:0]  ImgMatIn,
  input  logic [1:0]            Mode,
  input  logic                  ThreshEn,
  input  logic [IMAGE_BITS-1:0] Thresh,
  input  logic                  ReqIn,
  output logic                  AckIn,
  output logic                  ReqOut,
  input  logic                  AckOut,
  output logic [FLAT_WIDE-1:0]  ImgMatOut,
  output logic [FLAT_WIDE-1:0]  ppImgMatOut,
  output logic                  Busy
);

  localparam int ROW_W    = (MATRIX_N > 2) ? $clog2(MATRIX_N) : 1;
  localparam int ROW_BITS = IMAGE_BITS * MATRIX_N;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PROC = 2'd1,
    REQ  = 2'd2,
    REL  = 2'd3
  } stateType;

  stateType               r_state;
  stateType               w_nextState;
  logic [ROW_W-1:0]       r_row;
  logic [FLAT_WIDE-1:0]   r_capMat;
  logic [1:0]             r_mode;
  logic                   r_threshEn;
  logic [IMAGE_BITS-1:0]  r_thresh;
  logic                   r_ackIn;
  logic                   r_reqOut;
  logic [FLAT_WIDE-1:0]   r_imgOut;
  logic [FLAT_WIDE-1:0]   r_ppOut;
  logic [ROW_BITS-1:0]    w_rotRow;
  logic [ROW_BITS-1:0]    w_ppRow;
  logic                   w_capture;
  logic                   w_lastRow;

  // Flat index of the captured pixel that lands at out(r,c) for a rotation mode.
  function automatic int srcIndex(input logic [1:0] mode, input int r, input int c);
    int idx;
    case (mode)
      2'd0:    idx = r * MATRIX_N + c;
      2'd1:    idx = (MATRIX_N - 1 - c) * MATRIX_N + r;
      2'd2:    idx = (MATRIX_N - 1 - r) * MATRIX_N + (MATRIX_N - 1 - c);
      default: idx = c * MATRIX_N + (MATRIX_N - 1 - r);
    endcase
    return idx;
  endfunction

  // A new frame is only accepted in IDLE once the previous acknowledge has been released.
  assign w_capture = (r_state == IDLE) && ReqIn && !r_ackIn;
  assign w_lastRow = (r_row == ROW_W'(MATRIX_N - 1));

  // Build the rotated row selected by the row counter and its thresholded copy.
  always_comb begin
    w_rotRow = '0;
    w_ppRow  = '0;
    for (int c = 0; c < MATRIX_N; c++) begin
      w_rotRow[c*IMAGE_BITS +: IMAGE_BITS] =
        r_capMat[IMAGE_BITS*srcIndex(r_mode, int'(r_row), c) +: IMAGE_BITS];
      if (r_threshEn) begin
        w_ppRow[c*IMAGE_BITS +: IMAGE_BITS] =
          (w_rotRow[c*IMAGE_BITS +: IMAGE_BITS] >= r_thresh) ? {IMAGE_BITS{1'b1}} : {IMAGE_BITS{1'b0}};
      end else begin
        w_ppRow[c*IMAGE_BITS +: IMAGE_BITS] = w_rotRow[c*IMAGE_BITS +: IMAGE_BITS];
      end
    end
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode; the downstream ack only counts once ReqOut is actually raised.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: if (w_capture)          w_nextState = PROC;
      PROC: if (w_lastRow)          w_nextState = REQ;
      REQ:  if (r_reqOut && AckOut) w_nextState = REL;
      REL:  if (!AckOut)            w_nextState = IDLE;
      default:                      w_nextState = IDLE;
    endcase
  end

  // Capture registers, row counter and the row-by-row output writes.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_capMat   <= '0;
      r_mode     <= '0;
      r_threshEn <= 1'b0;
      r_thresh   <= '0;
      r_row      <= '0;
      r_imgOut   <= '0;
      r_ppOut    <= '0;
    end else begin
      if (w_capture) begin
        r_capMat   <= ImgMatIn;
        r_mode     <= Mode;
        r_threshEn <= ThreshEn;
        r_thresh   <= Thresh;
        r_row      <= '0;
      end else if (r_state == PROC) begin
        r_imgOut[ROW_BITS*int'(r_row) +: ROW_BITS] <= w_rotRow;
        r_ppOut[ROW_BITS*int'(r_row) +: ROW_BITS]  <= w_ppRow;
        r_row <= w_lastRow ? '0 : r_row + 1'b1;
      end
    end
  end

  // Handshake flags: AckIn follows the upstream request, ReqOut is raised one cycle into REQ.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_ackIn  <= 1'b0;
      r_reqOut <= 1'b0;
    end else begin
      if (w_capture) begin
        r_ackIn <= 1'b1;
      end else if (!ReqIn) begin
        r_ackIn <= 1'b0;
      end
      if (r_state == REQ) begin
        r_reqOut <= !(r_reqOut && AckOut);
      end else begin
        r_reqOut <= 1'b0;
      end
    end
  end

  assign AckIn       = r_ackIn;
  assign ReqOut      = r_reqOut;
  assign ImgMatOut   = r_imgOut;
  assign ppImgMatOut = r_ppOut;
  assign Busy        = (r_state != IDLE);

endmodule

// File: tb/tb_pre_processing_pipe.sv
// Testbench for pre_processing_pipe with a 4x4 matrix of 8-bit pixels.
// Expected images come from a 2-D array model that rotates by repeated quarter turns.
module tb_pre_processing_pipe;

  localparam int N    = 4;
  localparam int B    = 8;
  localparam int FLAT = B * N * N;

  logic            Clk = 1'b0;
  logic            Reset = 1'b1;
  logic [FLAT-1:0] ImgMatIn = '0;
  logic [1:0]      Mode = '0;
  logic            ThreshEn = 1'b0;
  logic [B-1:0]    Thresh = '0;
  logic            ReqIn = 1'b0;
  logic            AckIn;
  logic            ReqOut;
  logic            AckOut = 1'b0;
  logic [FLAT-1:0] ImgMatOut;
  logic [FLAT-1:0] ppImgMatOut;
  logic            Busy;

  int checks = 0;
  int errors = 0;

  pre_processing_pipe #(.IMAGE_BITS(B), .MATRIX_N(N)) dut (
    .Clk(Clk), .Reset(Reset), .ImgMatIn(ImgMatIn), .Mode(Mode), .ThreshEn(ThreshEn),
    .Thresh(Thresh), .ReqIn(ReqIn), .AckIn(AckIn), .ReqOut(ReqOut), .AckOut(AckOut),
    .ImgMatOut(ImgMatOut), .ppImgMatOut(ppImgMatOut), .Busy(Busy)
  );

  // Free-running clock.
  always #5 Clk = ~Clk;

  // Global time limit so the run can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic [1:0] mode;
    logic       ten;
    logic [7:0] thr;
    int         r;
    int         c;
    logic [7:0] expImg;
    logic [7:0] expPp;
  } vecType;

  task automatic checkOutput(input string name, input logic [FLAT-1:0] act, input logic [FLAT-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [FLAT-1:0] rampImage();
    logic [FLAT-1:0] img;
    img = '0;
    for (int i = 0; i < N*N; i++) img[B*i +: B] = B'(i);
    return img;
  endfunction

  function automatic logic [FLAT-1:0] randImage();
    logic [FLAT-1:0] img;
    for (int i = 0; i < FLAT/32; i++) img[32*i +: 32] = $urandom;
    return img;
  endfunction

  // Reference rotation: unpack to a grid, apply a 90-degree clockwise turn 'mode' times, repack.
  function automatic logic [FLAT-1:0] modelRotate(input logic [FLAT-1:0] img, input logic [1:0] mode);
    logic [B-1:0] grid [N][N];
    logic [B-1:0] turned [N][N];
    logic [FLAT-1:0] res;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        grid[r][c] = img[B*(r*N+c) +: B];
    for (int t = 0; t < int'(mode); t++) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          turned[r][c] = grid[N-1-c][r];
      grid = turned;
    end
    res = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        res[B*(r*N+c) +: B] = grid[r][c];
    return res;
  endfunction

  function automatic logic [FLAT-1:0] modelThresh(input logic [FLAT-1:0] img, input logic ten, input logic [B-1:0] thr);
    logic [FLAT-1:0] res;
    res = img;
    if (ten)
      for (int i = 0; i < N*N; i++)
        res[B*i +: B] = (img[B*i +: B] >= thr) ? 8'hFF : 8'h00;
    return res;
  endfunction

  // Waits (bounded) until ReqOut reaches the wanted level; returns the number of cycles waited.
  task automatic waitReqOut(input logic level, output int cycles);
    cycles = 0;
    while (ReqOut !== level && cycles < 40) begin
      @(negedge Clk);
      cycles++;
    end
  endtask

  // Waits (bounded) for the block to be idle with AckIn released.
  task automatic waitIdle(input string name);
    int cnt;
    cnt = 0;
    while ((Busy !== 1'b0 || AckIn !== 1'b0) && cnt < 40) begin
      @(negedge Clk);
      cnt++;
    end
    checkOutput(name, FLAT'(cnt < 40), FLAT'(1));
  endtask

  // Runs a full frame and compares everything against the model; inputs are scrambled after capture.
  task automatic applyStimulus(input logic [FLAT-1:0] img, input logic [1:0] mode, input logic ten,
                               input logic [B-1:0] thr, input bit earlyAck);
    logic [FLAT-1:0] expImg;
    logic [FLAT-1:0] expPp;
    int cycles;
    expImg = modelRotate(img, mode);
    expPp  = modelThresh(expImg, ten, thr);
    @(negedge Clk);
    ImgMatIn = img; Mode = mode; ThreshEn = ten; Thresh = thr; ReqIn = 1'b1; AckOut = earlyAck;
    @(negedge Clk);
    checkOutput("ackin_set", FLAT'(AckIn), FLAT'(1));
    checkOutput("busy_set", FLAT'(Busy), FLAT'(1));
    ImgMatIn = randImage(); Mode = 2'($urandom); ThreshEn = 1'($urandom); Thresh = 8'($urandom);
    waitReqOut(1'b1, cycles);
    checkOutput("latency", FLAT'(cycles), FLAT'(N + 1));
    checkOutput("img", ImgMatOut, expImg);
    checkOutput("pp", ppImgMatOut, expPp);
    if (earlyAck) begin
      @(negedge Clk);
      checkOutput("reqout_pulse", FLAT'(ReqOut), FLAT'(0));
      checkOutput("rel_busy", FLAT'(Busy), FLAT'(1));
      AckOut = 1'b0;
    end else begin
      AckOut = 1'b1;
      waitReqOut(1'b0, cycles);
      checkOutput("reqout_drop", FLAT'(cycles), FLAT'(1));
      AckOut = 1'b0;
    end
    ReqIn = 1'b0;
    waitIdle("idle_timeout");
    checkOutput("img_hold", ImgMatOut, expImg);
  endtask

  initial begin
    vecType vecs[10];
    logic [FLAT-1:0] ramp;
    logic [FLAT-1:0] other;
    logic [FLAT-1:0] expImg;
    int cycles;

    vecs[0] = '{2'd1, 1'b0, 8'd0, 0, 0, 8'd12, 8'd12};
    vecs[1] = '{2'd1, 1'b0, 8'd0, 0, 3, 8'd0,  8'd0};
    vecs[2] = '{2'd1, 1'b0, 8'd0, 3, 3, 8'd3,  8'd3};
    vecs[3] = '{2'd0, 1'b0, 8'd0, 1, 2, 8'd6,  8'd6};
    vecs[4] = '{2'd2, 1'b0, 8'd0, 0, 0, 8'd15, 8'd15};
    vecs[5] = '{2'd3, 1'b0, 8'd0, 0, 0, 8'd3,  8'd3};
    vecs[6] = '{2'd3, 1'b0, 8'd0, 3, 0, 8'd0,  8'd0};
    vecs[7] = '{2'd0, 1'b1, 8'd8, 1, 3, 8'd7,  8'h00};
    vecs[8] = '{2'd0, 1'b1, 8'd8, 2, 0, 8'd8,  8'hFF};
    vecs[9] = '{2'd0, 1'b1, 8'd8, 3, 3, 8'd15, 8'hFF};
    ramp = rampImage();

    // Reset with random inputs.
    ImgMatIn = randImage(); Mode = 2'($urandom); ThreshEn = 1'($urandom);
    Thresh = 8'($urandom); ReqIn = 1'($urandom); AckOut = 1'($urandom);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    checkOutput("rst_ackin", FLAT'(AckIn), FLAT'(0));
    checkOutput("rst_reqout", FLAT'(ReqOut), FLAT'(0));
    checkOutput("rst_busy", FLAT'(Busy), FLAT'(0));
    checkOutput("rst_img", ImgMatOut, '0);
    checkOutput("rst_pp", ppImgMatOut, '0);
    ReqIn = 1'b0; AckOut = 1'b0; Reset = 1'b0;

    // Directed pixel table on the ramp image.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(ramp, vecs[i].mode, vecs[i].ten, vecs[i].thr, 1'b0);
      checkOutput($sformatf("vec%0d_img", i), FLAT'(ImgMatOut[B*(vecs[i].r*N+vecs[i].c) +: B]), FLAT'(vecs[i].expImg));
      checkOutput($sformatf("vec%0d_pp", i), FLAT'(ppImgMatOut[B*(vecs[i].r*N+vecs[i].c) +: B]), FLAT'(vecs[i].expPp));
    end

    // Downstream ack already high when ReqOut rises.
    applyStimulus(randImage(), 2'd2, 1'b1, 8'd128, 1'b1);

    // ReqIn held high across a stalled transfer.
    @(negedge Clk);
    ImgMatIn = ramp; Mode = 2'd1; ThreshEn = 1'b0; ReqIn = 1'b1; AckOut = 1'b0;
    expImg = modelRotate(ramp, 2'd1);
    @(negedge Clk);
    checkOutput("hold_ackin", FLAT'(AckIn), FLAT'(1));
    waitReqOut(1'b1, cycles);
    checkOutput("hold_latency", FLAT'(cycles), FLAT'(N + 1));
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      checkOutput("stall_reqout", FLAT'(ReqOut), FLAT'(1));
      checkOutput("stall_img", ImgMatOut, expImg);
    end
    AckOut = 1'b1;
    waitReqOut(1'b0, cycles);
    checkOutput("stall_drop", FLAT'(cycles), FLAT'(1));
    AckOut = 1'b0;
    cycles = 0;
    while (Busy !== 1'b0 && cycles < 40) begin
      @(negedge Clk);
      cycles++;
    end
    checkOutput("stall_idle", FLAT'(cycles < 40), FLAT'(1));
    other = randImage();
    ImgMatIn = other; Mode = 2'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      checkOutput("no_recapture_busy", FLAT'(Busy), FLAT'(0));
      checkOutput("no_recapture_ack", FLAT'(AckIn), FLAT'(1));
    end
    checkOutput("no_recapture_img", ImgMatOut, expImg);
    ReqIn = 1'b0;
    @(negedge Clk);
    checkOutput("ackin_clear", FLAT'(AckIn), FLAT'(0));
    applyStimulus(other, 2'd0, 1'b0, 8'd0, 1'b0);

    // Reset in the middle of PROC (row counter at 2).
    @(negedge Clk);
    ImgMatIn = ramp; Mode = 2'd0; ThreshEn = 1'b0; ReqIn = 1'b1;
    @(negedge Clk);
    repeat (2) @(negedge Clk);
    Reset = 1'b1; ReqIn = 1'b0;
    @(negedge Clk);
    checkOutput("midrst_busy", FLAT'(Busy), FLAT'(0));
    checkOutput("midrst_ackin", FLAT'(AckIn), FLAT'(0));
    checkOutput("midrst_reqout", FLAT'(ReqOut), FLAT'(0));
    checkOutput("midrst_img", ImgMatOut, '0);
    checkOutput("midrst_pp", ppImgMatOut, '0);
    Reset = 1'b0;
    applyStimulus(ramp, 2'd3, 1'b1, 8'd5, 1'b0);

    // Randomised frames against the model.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(randImage(), 2'($urandom), 1'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
